// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between instruction fetch and stage-three data access.
// Grant in IDLE, WAIT_CYCLES BUSY cycles, registered one-cycle valid; requesters stall until their valid.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, HALT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WCW-1:0]    wait_cnt;
    logic [SCW-1:0]    starve_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_wdata;

    logic d_elig;
    logic i_elig;
    logic force_if;
    logic grant_d;
    logic grant_i;
    logic busy;
    logic last_busy;

    // A request seen in the same cycle as its own valid pulse is the one just completed.
    assign d_elig    = d_req & ~d_valid;
    assign i_elig    = if_req & ~if_valid;
    assign force_if  = (STARVE_LIMIT != 0) && (starve_cnt == SCW'(STARVE_LIMIT));
    assign busy      = (state == BUSY_D) || (state == BUSY_I);
    assign last_busy = (wait_cnt == WCW'(WAIT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            IDLE: begin
                if (halt_sys) begin
                    state_nxt = HALT;
                end else if (d_elig && i_elig) begin
                    grant_i = force_if;
                    grant_d = ~force_if;
                end else begin
                    grant_d = d_elig;
                    grant_i = i_elig;
                end
                if (grant_d) state_nxt = BUSY_D;
                if (grant_i) state_nxt = BUSY_I;
            end
            BUSY_D, BUSY_I: begin
                if (last_busy) state_nxt = IDLE;
            end
            HALT: begin
                if (!halt_sys) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_address    = '0;
        mem_write_en   = 1'b0;
        mem_write_data = '0;
        if (busy) begin
            mem_address = lat_addr;
            if (lat_wr) mem_write_data = lat_wdata;
            // Write strobe only once so a long wait never re-commits the store.
            mem_write_en = (state == BUSY_D) && lat_wr && (wait_cnt == '0);
        end
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            lat_addr   <= '0;
            lat_wr     <= 1'b0;
            lat_wdata  <= '0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            d_rdata    <= '0;
            d_valid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (grant_d || grant_i) begin
                lat_addr  <= grant_d ? d_addr : if_addr;
                lat_wr    <= grant_d & d_wr;
                lat_wdata <= grant_d ? d_wdata : '0;
                wait_cnt  <= '0;
            end else if (busy) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (busy && last_busy) begin
                if (state == BUSY_I) begin
                    if_rdata <= mem_data_out;
                    if_valid <= 1'b1;
                end else begin
                    if (!lat_wr) d_rdata <= mem_data_out;
                    d_valid <= 1'b1;
                end
            end

            if (grant_i || (state == IDLE && !if_req)) begin
                starve_cnt <= '0;
            end else if (grant_d && if_req && (starve_cnt != SCW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: main instance with WAIT_CYCLES=1, second with WAIT_CYCLES=3.
// Stimulus pushes hand-computed responses; negedge monitors pop and compare on every valid pulse.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp3_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          wr_count = 0;
    bit          halt_on_dvalid = 1'b0;

    // main instance signals
    logic        halt_sys = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        stall_if;
    logic        stall_mem;
    logic [15:0] mem_address;
    logic        mem_write_en;
    logic [15:0] mem_write_data;
    logic [15:0] mem_data_out;

    logic [15:0] mem1 [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_dat = '0;

    always @(posedge clk) begin
        if (mem_write_en) mem1[mem_address[7:0]] <= mem_write_data;
        else if (pre_we)  mem1[pre_addr] <= pre_dat;
    end
    always @(posedge clk) if (mem_write_en) wr_count <= wr_count + 1;
    assign mem_data_out = mem1[mem_address[7:0]];

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_address(mem_address), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_data_out(mem_data_out)
    );

    // long-wait instance; its memory is a single word at 0x0030
    logic        halt3 = 1'b0;
    logic        if3_req = 1'b0;
    logic [15:0] if3_addr = '0;
    logic [15:0] if3_rdata;
    logic        if3_valid;
    logic        d3_req = 1'b0;
    logic        d3_wr = 1'b0;
    logic [15:0] d3_addr = '0;
    logic [15:0] d3_wdata = '0;
    logic [15:0] d3_rdata;
    logic        d3_valid;
    logic        stall_if3;
    logic        stall_mem3;
    logic [15:0] mem3_addr;
    logic        mem3_we;
    logic [15:0] mem3_wdata;
    logic [15:0] mem3_dout;
    logic [15:0] mem3_word = 16'h5A5A;

    assign mem3_dout = (mem3_addr == 16'h0030) ? mem3_word : 16'h0000;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .rst(rst), .halt_sys(halt3),
        .if_req(if3_req), .if_addr(if3_addr), .if_rdata(if3_rdata), .if_valid(if3_valid),
        .d_req(d3_req), .d_wr(d3_wr), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_rdata(d3_rdata), .d_valid(d3_valid),
        .stall_if(stall_if3), .stall_mem(stall_mem3),
        .mem_address(mem3_addr), .mem_write_en(mem3_we),
        .mem_write_data(mem3_wdata), .mem_data_out(mem3_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got no valid within budget expected valid pulse", name);
    endtask

    task automatic check_resp(input bit is_d, input logic [15:0] data);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL resp_unexpected: got %s/%h expected no completion", is_d ? "D" : "I", data);
        end else begin
            e = exp_q.pop_front();
            if (e.is_d != is_d || e.data !== data) begin
                n_miss++;
                $display("FAIL resp: got %s/%h expected %s/%h",
                         is_d ? "D" : "I", data, e.is_d ? "D" : "I", e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (d_valid)  check_resp(1'b1, d_rdata);
            if (if_valid) check_resp(1'b0, if_rdata);
        end
    end

    always @(negedge clk) begin
        if (!rst && d3_valid) begin
            n_vec++;
            if (exp3_q.size() == 0) begin
                n_miss++;
                $display("FAIL resp3_unexpected: got %h expected no completion", d3_rdata);
            end else if (d3_rdata !== exp3_q[0]) begin
                n_miss++;
                $display("FAIL resp3: got %h expected %h", d3_rdata, exp3_q[0]);
                void'(exp3_q.pop_front());
            end else begin
                void'(exp3_q.pop_front());
            end
        end
        if (!rst && if3_valid) chk("if3_unexpected", {31'd0, if3_valid}, 32'd0);
    end

    task automatic push_exp(input bit is_d, input logic [15:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_d(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (d_valid) begin
                done  = 1'b1;
                d_req = 1'b0;
                // Parks the arbiter for a cycle so IF cannot slip in on D's completion cycle.
                if (halt_on_dvalid) begin
                    halt_sys = 1'b1;
                    @(negedge clk);
                    halt_sys = 1'b0;
                end
            end
        end
        if (!done) begin
            d_req = 1'b0;
            timeout("d_timeout");
        end
    endtask

    task automatic wait_i(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (if_valid) begin
                done   = 1'b1;
                if_req = 1'b0;
            end
        end
        if (!done) begin
            if_req = 1'b0;
            timeout("if_timeout");
        end
    endtask

    task automatic d_access(input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
        d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        wait_d(40);
    endtask

    task automatic i_access(input logic [15:0] addr);
        if_req = 1'b1; if_addr = addr;
        wait_i(60);
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_dat = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    initial begin
        int snap;

        preload(8'h10, 16'hBEEF);
        preload(8'h40, 16'h1111);
        for (int k = 0; k < 5; k++) preload(8'h50 + 8'(k), 16'hA001 + 16'(k));

        // reset state
        chk("rst_if_valid", {31'd0, if_valid}, 0);
        chk("rst_d_valid", {31'd0, d_valid}, 0);
        chk("rst_if_rdata", {16'd0, if_rdata}, 0);
        chk("rst_d_rdata", {16'd0, d_rdata}, 0);
        chk("rst_mem_addr", {16'd0, mem_address}, 0);
        chk("rst_mem_we", {31'd0, mem_write_en}, 0);
        chk("rst_mem_wdata", {16'd0, mem_write_data}, 0);
        chk("rst_stalls", {30'd0, stall_if, stall_mem}, 0);
        chk("rst3_outputs", {15'd0, d3_valid, mem3_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single IF read
        push_exp(1'b0, 16'hBEEF);
        if_req = 1'b1; if_addr = 16'h0010;
        #1 chk("t1_stall_c0", {31'd0, stall_if}, 1);
        @(negedge clk);
        chk("t1_busy_addr", {16'd0, mem_address}, 32'h10);
        chk("t1_valid_c1", {31'd0, if_valid}, 0);
        chk("t1_stall_c1", {31'd0, stall_if}, 1);
        @(negedge clk);
        chk("t1_valid_c2", {31'd0, if_valid}, 1);
        chk("t1_stall_c2", {31'd0, stall_if}, 0);
        if_req = 1'b0;
        @(negedge clk);
        chk("t1_pulse_one", {31'd0, if_valid}, 0);
        chk("t1_idle_addr", {16'd0, mem_address}, 0);

        // simultaneous write and read: MEM first, then IF reads the written word
        snap = wr_count;
        push_exp(1'b1, 16'h0000);
        push_exp(1'b0, 16'h1234);
        fork
            d_access(1'b1, 16'h0020, 16'h1234);
            i_access(16'h0020);
        join
        @(negedge clk);
        chk("t2_we_cycles", wr_count - snap, 1);

        // starvation: four MEM grants with IF pending, then IF forced, then MEM again
        repeat (2) @(negedge clk);
        halt_on_dvalid = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(1'b1, 16'hA001 + 16'(k));
        push_exp(1'b0, 16'hBEEF);
        push_exp(1'b1, 16'hA005);
        fork
            for (int k = 0; k < 5; k++) d_access(1'b0, 16'h0050 + 16'(k), 16'h0);
            i_access(16'h0010);
        join
        halt_on_dvalid = 1'b0;
        repeat (3) @(negedge clk);

        // halt during a MEM read: completes, then IF waits until release
        push_exp(1'b1, 16'h1234);
        push_exp(1'b0, 16'hBEEF);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        @(negedge clk);
        chk("t5_busy_addr", {16'd0, mem_address}, 32'h20);
        halt_sys = 1'b1; if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        chk("t5_d_valid", {31'd0, d_valid}, 1);
        d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_halt_no_grant", {15'd0, if_valid, mem_address}, 0);
            chk("t5_halt_stall", {31'd0, stall_if}, 1);
        end
        halt_sys = 1'b0;
        wait_i(10);
        repeat (2) @(negedge clk);

        // reset in the middle of a write
        snap = wr_count;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h7777;
        @(negedge clk);
        chk("t6_we_before", {31'd0, mem_write_en}, 1);
        rst = 1'b1; d_req = 1'b0;
        #1;
        chk("t6_addr", {16'd0, mem_address}, 0);
        chk("t6_we", {31'd0, mem_write_en}, 0);
        chk("t6_wdata", {16'd0, mem_write_data}, 0);
        chk("t6_valids", {30'd0, d_valid, if_valid}, 0);
        chk("t6_rdata", {if_rdata, d_rdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_no_write", wr_count - snap, 0);
        push_exp(1'b0, 16'h1111);
        i_access(16'h0040);

        // long-wait read on the second instance
        exp3_q.push_back(16'hC3C3);
        @(negedge clk);
        d3_req = 1'b1; d3_wr = 1'b0; d3_addr = 16'h0030;
        #1 chk("t4_c0_addr", {16'd0, mem3_addr}, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("t4_busy_addr", {16'd0, mem3_addr}, 32'h30);
            chk("t4_busy_valid", {31'd0, d3_valid}, 0);
            chk("t4_busy_we", {15'd0, mem3_we, mem3_wdata}, 0);
            chk("t4_stall", {31'd0, stall_mem3}, 1);
            if (c == 2) mem3_word = 16'hC3C3;
        end
        @(negedge clk);
        chk("t4_valid_c4", {31'd0, d3_valid}, 1);
        chk("t4_addr_c4", {16'd0, mem3_addr}, 0);
        chk("t4_stall_c4", {31'd0, stall_mem3}, 0);
        d3_req = 1'b0;
        @(negedge clk);
        chk("t4_pulse_one", {31'd0, d3_valid}, 0);

        repeat (3) @(negedge clk);
        chk("leftover_exp", exp_q.size(), 0);
        chk("leftover_exp3", exp3_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
